// File: rtl/stream_sequencer.sv
// stream_sequencer
//   Drives one serial (in, x) -> out datapath from a frame of FRAME_LEN bit
//   pairs, feeding pair 0 first, one pair per cycle, and collects the
//   returned out bits into result_data (bit k belongs to pair k). The
//   datapath's reset_n is owned here: it is held low outside RUN.
//
//   Optional feature macro: STREAM_SEQ_CHECK_EN adds frame_exp,
//   result_match and mismatch_count.
//
// Parameters
//   FRAME_LEN     bit pairs per frame (>= 1)
//   OUT_LAT       cycles from a pair being driven to its out bit (0 = Mealy)
//   FLUSH_CYCLES  cycles dut_reset_n is held low before each run (0 = none)
//
// Ports
//   clock, reset_n              clock (posedge), async active-low reset
//   frame_valid/frame_ready     frame handshake; frame_in/frame_x payload
//   abort                       cancels a frame in FLUSH or RUN
//   dut_reset_n/dut_in/dut_x    drive to the datapath; dut_out returned bit
//   result_valid/result_ready   result handshake; result_data payload
//   frame_exp (opt)             expected result, latched with the frame
//   result_match (opt)          result_data == frame_exp, valid with result
//   mismatch_count (opt)        saturating count of mismatching results
//   busy                        sequencer not idle
module stream_sequencer #(
    parameter int unsigned FRAME_LEN    = 8,
    parameter int unsigned OUT_LAT      = 1,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 frame_valid,
    output logic                 frame_ready,
    input  logic [FRAME_LEN-1:0] frame_in,
    input  logic [FRAME_LEN-1:0] frame_x,
    input  logic                 abort,
    output logic                 dut_reset_n,
    output logic                 dut_in,
    output logic                 dut_x,
    input  logic                 dut_out,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic [FRAME_LEN-1:0] result_data,
`ifdef STREAM_SEQ_CHECK_EN
    input  logic [FRAME_LEN-1:0] frame_exp,
    output logic                 result_match,
    output logic [15:0]          mismatch_count,
`endif
    output logic                 busy
);

    localparam int unsigned LAST = FRAME_LEN + OUT_LAT - 1;
    localparam int unsigned CW   = $clog2(FRAME_LEN + OUT_LAT + 1);
    localparam int unsigned FW   = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, FLUSH, RUN, DONE} state_t;

    state_t               state, state_next;
    logic [CW-1:0]        cnt, cnt_next;
    logic [FW-1:0]        fcnt, fcnt_next;
    logic [FRAME_LEN-1:0] in_q, x_q;
    logic [FRAME_LEN-1:0] in_src, x_src, in_shift, x_shift;
    logic [FRAME_LEN-1:0] cap_mask;
    logic                 accept, deliver, capture;
    logic                 in_next, x_next;

    // frame_ready is only ever 1 in IDLE and result_valid only in DONE,
    // so the handshakes need no extra state qualification.
    assign accept  = frame_valid && frame_ready;
    assign deliver = result_valid && result_ready;
    assign capture = (state == RUN) && (cnt >= CW'(OUT_LAT));

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        fcnt_next  = fcnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    cnt_next   = '0;
                    fcnt_next  = '0;
                    state_next = (FLUSH_CYCLES == 0) ? RUN : FLUSH;
                end
            end
            FLUSH: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (fcnt == FW'(FLUSH_CYCLES - 1)) begin
                    state_next = RUN;
                    cnt_next   = '0;
                end else begin
                    fcnt_next = fcnt + 1'b1;
                end
            end
            RUN: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (cnt == CW'(LAST)) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            DONE: begin
                if (deliver) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Pair drive is registered from the next state/count so the pair for
    // cnt is on the pins during cycle cnt. With no flush the first pair
    // must come straight from the frame inputs being accepted.
    always_comb begin
        in_src   = accept ? frame_in : in_q;
        x_src    = accept ? frame_x  : x_q;
        in_shift = in_src >> cnt_next;
        x_shift  = x_src  >> cnt_next;
        in_next  = 1'b0;
        x_next   = 1'b0;
        if (state_next == RUN && cnt_next < CW'(FRAME_LEN)) begin
            in_next = in_shift[0];
            x_next  = x_shift[0];
        end
    end

    assign cap_mask = FRAME_LEN'(1) << (cnt - CW'(OUT_LAT));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            fcnt         <= '0;
            in_q         <= '0;
            x_q          <= '0;
            frame_ready  <= 1'b0;
            dut_reset_n  <= 1'b0;
            dut_in       <= 1'b0;
            dut_x        <= 1'b0;
            result_valid <= 1'b0;
            result_data  <= '0;
            busy         <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            fcnt         <= fcnt_next;
            // Ready lags an abort return to IDLE by a cycle but follows a
            // delivered result immediately.
            frame_ready  <= ((state == IDLE) && !accept) || deliver;
            result_valid <= (state == DONE) && !deliver;
            busy         <= (state_next != IDLE);
            dut_reset_n  <= (state_next == RUN);
            dut_in       <= in_next;
            dut_x        <= x_next;
            if (accept) begin
                in_q        <= frame_in;
                x_q         <= frame_x;
                result_data <= '0;
            end else if (capture) begin
                result_data <= dut_out ? (result_data | cap_mask)
                                       : (result_data & ~cap_mask);
            end
        end
    end

`ifdef STREAM_SEQ_CHECK_EN
    logic [FRAME_LEN-1:0] exp_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            exp_q          <= '0;
            result_match   <= 1'b0;
            mismatch_count <= '0;
        end else begin
            if (accept) begin
                exp_q <= frame_exp;
            end
            result_match <= (state == DONE) && !deliver && (result_data == exp_q);
            if (deliver && !result_match && mismatch_count != '1) begin
                mismatch_count <= mismatch_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_stream_sequencer.sv
// tb_stream_sequencer
//   Drives stream_sequencer (FRAME_LEN=8, OUT_LAT=1, FLUSH_CYCLES=2) against
//   a stub datapath whose out is in^x registered, reset to 0. Expected
//   results come from frame arithmetic: result = frame_in ^ frame_x, with
//   the drive window and latency derived from the frame timing rules.
module tb_stream_sequencer;

    localparam int unsigned L   = 8;
    localparam int unsigned O   = 1;
    localparam int unsigned F   = 2;
    localparam int unsigned LAT = F + L + O + 1;

    logic         clock        = 1'b0;
    logic         reset_n      = 1'b0;
    logic         frame_valid  = 1'b0;
    logic         abort        = 1'b0;
    logic         result_ready = 1'b0;
    logic [L-1:0] frame_in     = '0;
    logic [L-1:0] frame_x      = '0;
    logic         frame_ready, dut_reset_n, dut_in, dut_x, dut_out;
    logic         result_valid, busy;
    logic [L-1:0] result_data;
`ifdef STREAM_SEQ_CHECK_EN
    logic [L-1:0] frame_exp = '0;
    logic         result_match;
    logic [15:0]  mismatch_count;
    int unsigned  mm_model = 0;
    bit           flip;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    // Stub datapath.
    always_ff @(posedge clock or negedge dut_reset_n) begin
        if (!dut_reset_n) dut_out <= 1'b0;
        else              dut_out <= dut_in ^ dut_x;
    end

    stream_sequencer #(
        .FRAME_LEN   (L),
        .OUT_LAT     (O),
        .FLUSH_CYCLES(F)
    ) u_dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .frame_valid   (frame_valid),
        .frame_ready   (frame_ready),
        .frame_in      (frame_in),
        .frame_x       (frame_x),
        .abort         (abort),
        .dut_reset_n   (dut_reset_n),
        .dut_in        (dut_in),
        .dut_x         (dut_x),
        .dut_out       (dut_out),
        .result_valid  (result_valid),
        .result_ready  (result_ready),
        .result_data   (result_data),
`ifdef STREAM_SEQ_CHECK_EN
        .frame_exp     (frame_exp),
        .result_match  (result_match),
        .mismatch_count(mismatch_count),
`endif
        .busy          (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},  32'(busy), 32'd0);
        check({tag, "_drst"},  32'(dut_reset_n), 32'd0);
        check({tag, "_din"},   32'(dut_in), 32'd0);
        check({tag, "_dx"},    32'(dut_x), 32'd0);
        check({tag, "_rv"},    32'(result_valid), 32'd0);
    endtask

    task automatic wait_ready();
        int unsigned n = 0;
        while (frame_ready !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("ready_wait", 32'(frame_ready), 32'd1);
    endtask

    // Offers a frame at a negedge where frame_ready is 1; returns at the
    // negedge right after the accepting posedge (call it cycle 0).
    task automatic offer(input logic [L-1:0] fin, input logic [L-1:0] fx);
        wait_ready();
        frame_in    = fin;
        frame_x     = fx;
        frame_valid = 1'b1;
`ifdef STREAM_SEQ_CHECK_EN
        flip      = 1'($urandom_range(0, 1));
        frame_exp = (fin ^ fx) ^ L'(flip);
`endif
        @(negedge clock);
        frame_valid = 1'b0;
        frame_in    = ~fin;
        frame_x     = L'($urandom);
    endtask

    task automatic run_frame(input logic [L-1:0] fin, input logic [L-1:0] fx,
                             input int unsigned hold);
        logic [L-1:0] expv;
        logic         e_in, e_x;
        expv = fin ^ fx;
        offer(fin, fx);
        for (int unsigned i = 0; i < LAT; i++) begin
            e_in = 1'b0;
            e_x  = 1'b0;
            if (i >= F && i < F + L) begin
                e_in = fin[i-F];
                e_x  = fx[i-F];
            end
            check("busy_run", 32'(busy), 32'd1);
            check("rv_early", 32'(result_valid), 32'd0);
            check("drst_window", 32'(dut_reset_n), 32'(i >= F && i < F + L + O));
            check("din_pair", 32'(dut_in), 32'(e_in));
            check("dx_pair", 32'(dut_x), 32'(e_x));
            @(negedge clock);
        end
        check("rv_latency", 32'(result_valid), 32'd1);
        check("rdata", 32'(result_data), 32'(expv));
`ifdef STREAM_SEQ_CHECK_EN
        check("match", 32'(result_match), 32'(!flip));
`endif
        for (int unsigned h = 0; h < hold; h++) begin
            frame_valid = 1'b1;
            abort       = 1'($urandom_range(0, 1));
            @(negedge clock);
            check("rv_hold", 32'(result_valid), 32'd1);
            check("rdata_hold", 32'(result_data), 32'(expv));
            check("ready_hold", 32'(frame_ready), 32'd0);
            check("drst_done", 32'(dut_reset_n), 32'd0);
        end
        frame_valid  = 1'b0;
        abort        = 1'b0;
        result_ready = 1'b1;
        @(negedge clock);
        result_ready = 1'b0;
        check("ready_after_done", 32'(frame_ready), 32'd1);
        check_idle_outputs("after_done");
`ifdef STREAM_SEQ_CHECK_EN
        if (flip && mm_model != 32'hFFFF) mm_model++;
        check("mm_count", 32'(mismatch_count), mm_model);
`endif
    endtask

    task automatic abort_frame(input logic [L-1:0] fin, input logic [L-1:0] fx,
                               input int unsigned at);
        offer(fin, fx);
        repeat (at) @(negedge clock);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        check_idle_outputs("abort");
        check("ready_abort0", 32'(frame_ready), 32'd0);
        @(negedge clock);
        check("ready_abort1", 32'(frame_ready), 32'd1);
        for (int unsigned k = 0; k < LAT; k++) begin
            @(negedge clock);
            check("rv_after_abort", 32'(result_valid), 32'd0);
        end
    endtask

    task automatic reset_mid(input logic [L-1:0] fin, input logic [L-1:0] fx,
                             input int unsigned at);
        offer(fin, fx);
        repeat (at) @(negedge clock);
        check("drst_before_rst", 32'(dut_reset_n), 32'd1);
        reset_n = 1'b0;
        #1;
        check_idle_outputs("async_rst");
        check("ready_rst", 32'(frame_ready), 32'd0);
        check("rdata_rst", 32'(result_data), 32'd0);
        @(negedge clock);
        check("ready_in_rst", 32'(frame_ready), 32'd0);
        reset_n = 1'b1;
`ifdef STREAM_SEQ_CHECK_EN
        mm_model = 0;
        check("mm_rst", 32'(mismatch_count), 32'd0);
`endif
        @(negedge clock);
        check("ready_release", 32'(frame_ready), 32'd1);
        check("rdata_release", 32'(result_data), 32'd0);
    endtask

    initial begin
        #2;
        check_idle_outputs("reset");
        check("reset_ready", 32'(frame_ready), 32'd0);
        check("reset_rdata", 32'(result_data), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("ready_first", 32'(frame_ready), 32'd1);

        run_frame(8'hA5, 8'h0F, 0);
        run_frame(8'hA5, 8'h0F, 5);
        run_frame(8'hFF, 8'h00, 0);
        run_frame(8'h00, 8'h00, 0);
        abort_frame(8'hFF, 8'h00, F + 3);
        abort_frame(L'($urandom), L'($urandom), 0);
        abort_frame(8'hFF, 8'hF0, F + L + O - 1);
        for (int n = 0; n < 6; n++) begin
            run_frame(L'($urandom), L'($urandom), $urandom_range(0, 3));
        end
        reset_mid(8'hFF, 8'h00, F + 5);
        run_frame(L'($urandom), L'($urandom), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
